// File: rtl/prf_mp_pkg.sv
// rtl/prf_mp_pkg.sv - shared widths and types for the multi-ported physical register file
package prf_mp_pkg;

    localparam int EPOCH_W       = 4;
    localparam int FU_NUM        = 2;
    localparam int PRF_PHYS_REGS = 64;
    localparam int PRF_DW        = 32;
    localparam int PRF_PHYS_W    = $clog2(PRF_PHYS_REGS);

    typedef logic [PRF_PHYS_W-1:0] phys_idx_t;
    typedef logic [EPOCH_W-1:0]    epoch_t;

    typedef struct packed {
        logic              valid;
        phys_idx_t         pd;
        logic [PRF_DW-1:0] data;
        epoch_t            epoch;
    } wb_req_t;

endpackage

// File: rtl/prf_wb_arb.sv
// rtl/prf_wb_arb.sv - per-register resolution of writeback and allocate updates
module prf_wb_arb
    import prf_mp_pkg::*;
#(
    parameter int PHYS_REGS = PRF_PHYS_REGS,
    parameter int DW        = PRF_DW,
    parameter int PHYS_W    = $clog2(PHYS_REGS),
    parameter int NUM_WB    = 2,
    parameter int NUM_ALLOC = 2
) (
    input  logic [NUM_WB-1:0]                   i_wb_acc,
    input  logic [NUM_WB-1:0][PHYS_W-1:0]       i_wb_pd,
    input  logic [NUM_WB-1:0][DW-1:0]           i_wb_data,
    input  logic [NUM_ALLOC-1:0]                i_alloc_ok,
    input  logic [NUM_ALLOC-1:0][PHYS_W-1:0]    i_alloc_pd,
    input  logic [NUM_ALLOC-1:0][EPOCH_W-1:0]   i_alloc_epoch,
    output logic [PHYS_REGS-1:0]                o_mem_we,
    output logic [PHYS_REGS-1:0][DW-1:0]        o_mem_wdata,
    output logic [PHYS_REGS-1:0]                o_alloc_hit,
    output logic [PHYS_REGS-1:0][EPOCH_W-1:0]   o_epoch_wdata
);

    // Ascending port order lets the highest-index port win on a shared pd.
    always_comb begin
        o_mem_we      = '0;
        o_mem_wdata   = '0;
        o_alloc_hit   = '0;
        o_epoch_wdata = '0;
        for (int j = 0; j < NUM_WB; j++) begin
            if (i_wb_acc[j]) begin
                o_mem_we[i_wb_pd[j]]    = 1'b1;
                o_mem_wdata[i_wb_pd[j]] = i_wb_data[j];
            end
        end
        for (int k = 0; k < NUM_ALLOC; k++) begin
            if (i_alloc_ok[k]) begin
                o_alloc_hit[i_alloc_pd[k]]   = 1'b1;
                o_epoch_wdata[i_alloc_pd[k]] = i_alloc_epoch[k];
            end
        end
    end

endmodule

// File: rtl/prf_mp.sv
// rtl/prf_mp.sv - multi-ported epoch-filtered physical register file with bypass and wakeup
module prf_mp
    import prf_mp_pkg::*;
#(
    parameter int PHYS_REGS = PRF_PHYS_REGS,
    parameter int DW        = PRF_DW,
    parameter int PHYS_W    = $clog2(PHYS_REGS),
    parameter int NUM_RD    = FU_NUM,
    parameter int NUM_WB    = 2,
    parameter int NUM_ALLOC = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG  = 1,
    parameter int CNT_W     = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_RD-1:0][PHYS_W-1:0]       raddr1,
    output logic [NUM_RD-1:0][DW-1:0]           rdata1,
    output logic [NUM_RD-1:0]                   rready1,
    input  logic [NUM_RD-1:0][PHYS_W-1:0]       raddr2,
    output logic [NUM_RD-1:0][DW-1:0]           rdata2,
    output logic [NUM_RD-1:0]                   rready2,
    input  logic [NUM_ALLOC-1:0]                alloc_valid,
    input  logic [NUM_ALLOC-1:0][PHYS_W-1:0]    alloc_pd,
    input  logic [NUM_ALLOC-1:0][EPOCH_W-1:0]   alloc_epoch,
    input  logic [NUM_WB-1:0]                   wb_valid,
    input  logic [NUM_WB-1:0][PHYS_W-1:0]       wb_pd,
    input  logic [NUM_WB-1:0][DW-1:0]           wb_data,
    input  logic [NUM_WB-1:0][EPOCH_W-1:0]      wb_epoch,
    output logic [NUM_WB-1:0]                   wakeup_valid,
    output logic [NUM_WB-1:0][PHYS_W-1:0]       wakeup_pd,
    output logic [CNT_W-1:0]                    stale_drop_cnt,
    output logic [PHYS_REGS-1:0]                ready_vec
);

    logic [PHYS_REGS-1:0][DW-1:0]       r_mem;
    logic [PHYS_REGS-1:0]               r_ready;
    logic [PHYS_REGS-1:0][EPOCH_W-1:0]  r_epoch;
    logic [NUM_WB-1:0]                  r_wk_valid;
    logic [NUM_WB-1:0][PHYS_W-1:0]      r_wk_pd;
    logic [CNT_W-1:0]                   r_cnt;

    logic [NUM_WB-1:0]                  w_wb_acc;
    logic [NUM_WB-1:0]                  w_wb_stale;
    logic [NUM_ALLOC-1:0]               w_alloc_ok;
    logic [PHYS_REGS-1:0]               w_mem_we;
    logic [PHYS_REGS-1:0][DW-1:0]       w_mem_wdata;
    logic [PHYS_REGS-1:0]               w_alloc_hit;
    logic [PHYS_REGS-1:0][EPOCH_W-1:0]  w_epoch_wdata;
    logic [CNT_W:0]                     w_cnt_sum;
    logic [CNT_W-1:0]                   w_cnt_next;

    // Register 0 traffic is filtered here so it is neither stored, counted nor woken.
    always_comb begin
        w_wb_acc   = '0;
        w_wb_stale = '0;
        w_alloc_ok = '0;
        for (int j = 0; j < NUM_WB; j++) begin
            if (wb_valid[j] && !(ZERO_REG != 0 && wb_pd[j] == '0)) begin
                w_wb_acc[j]   = (r_epoch[wb_pd[j]] == wb_epoch[j]);
                w_wb_stale[j] = (r_epoch[wb_pd[j]] != wb_epoch[j]);
            end
        end
        for (int k = 0; k < NUM_ALLOC; k++) begin
            w_alloc_ok[k] = alloc_valid[k] && !(ZERO_REG != 0 && alloc_pd[k] == '0);
        end
    end

    prf_wb_arb #(
        .PHYS_REGS (PHYS_REGS),
        .DW        (DW),
        .PHYS_W    (PHYS_W),
        .NUM_WB    (NUM_WB),
        .NUM_ALLOC (NUM_ALLOC)
    ) u_arb (
        .i_wb_acc      (w_wb_acc),
        .i_wb_pd       (wb_pd),
        .i_wb_data     (wb_data),
        .i_alloc_ok    (w_alloc_ok),
        .i_alloc_pd    (alloc_pd),
        .i_alloc_epoch (alloc_epoch),
        .o_mem_we      (w_mem_we),
        .o_mem_wdata   (w_mem_wdata),
        .o_alloc_hit   (w_alloc_hit),
        .o_epoch_wdata (w_epoch_wdata)
    );

    always_comb begin
        w_cnt_sum = {1'b0, r_cnt};
        for (int j = 0; j < NUM_WB; j++) begin
            w_cnt_sum = w_cnt_sum + (CNT_W+1)'(w_wb_stale[j]);
        end
        w_cnt_next = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
    end

    always_comb begin
        rdata1  = '0;
        rready1 = '0;
        rdata2  = '0;
        rready2 = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rdata1[p]  = r_mem[raddr1[p]];
            rready1[p] = r_ready[raddr1[p]];
            rdata2[p]  = r_mem[raddr2[p]];
            rready2[p] = r_ready[raddr2[p]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WB; j++) begin
                    if (w_wb_acc[j] && !w_alloc_hit[wb_pd[j]]) begin
                        if (wb_pd[j] == raddr1[p]) begin
                            rdata1[p]  = wb_data[j];
                            rready1[p] = 1'b1;
                        end
                        if (wb_pd[j] == raddr2[p]) begin
                            rdata2[p]  = wb_data[j];
                            rready2[p] = 1'b1;
                        end
                    end
                end
            end
            if (ZERO_REG != 0 && raddr1[p] == '0) begin
                rdata1[p]  = '0;
                rready1[p] = 1'b1;
            end
            if (ZERO_REG != 0 && raddr2[p] == '0) begin
                rdata2[p]  = '0;
                rready2[p] = 1'b1;
            end
        end
    end

    // Allocate owns ready and epoch; an accepted writeback only sets ready when no allocate collides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem      <= '0;
            r_ready    <= '1;
            r_epoch    <= '0;
            r_wk_valid <= '0;
            r_wk_pd    <= '0;
            r_cnt      <= '0;
        end else begin
            for (int i = 0; i < PHYS_REGS; i++) begin
                if (w_mem_we[i]) begin
                    r_mem[i] <= w_mem_wdata[i];
                end
                if (w_alloc_hit[i]) begin
                    r_ready[i] <= 1'b0;
                    r_epoch[i] <= w_epoch_wdata[i];
                end else if (w_mem_we[i]) begin
                    r_ready[i] <= 1'b1;
                end
            end
            r_wk_valid <= w_wb_acc;
            r_wk_pd    <= wb_pd;
            r_cnt      <= w_cnt_next;
        end
    end

    assign wakeup_valid   = r_wk_valid;
    assign wakeup_pd      = r_wk_pd;
    assign stale_drop_cnt = r_cnt;
    assign ready_vec      = r_ready | PHYS_REGS'(ZERO_REG != 0);

endmodule

// File: tb/tb_prf_mp.sv
// tb/tb_prf_mp.sv - scoreboard bench for prf_mp reads, epochs, wakeup and stale counting
module tb_prf_mp;
    import prf_mp_pkg::*;

    localparam int CW = 4;

    logic clk;
    logic rst_n;
    logic [1:0][5:0]  raddr1, raddr2;
    logic [1:0][31:0] rdata1, rdata2;
    logic [1:0]       rready1, rready2;
    logic [1:0]       alloc_valid;
    logic [1:0][5:0]  alloc_pd;
    logic [1:0][3:0]  alloc_epoch;
    logic [1:0]       wb_valid;
    logic [1:0][5:0]  wb_pd;
    logic [1:0][31:0] wb_data;
    logic [1:0][3:0]  wb_epoch;
    logic [1:0]       wakeup_valid;
    logic [1:0][5:0]  wakeup_pd;
    logic [CW-1:0]    stale_drop_cnt;
    logic [63:0]      ready_vec;

    int total = 0;
    int bad   = 0;

    typedef struct { int port; int pd; } wk_t;
    wk_t wk_q[$];

    prf_mp #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .raddr1(raddr1), .rdata1(rdata1), .rready1(rready1),
        .raddr2(raddr2), .rdata2(rdata2), .rready2(rready2),
        .alloc_valid(alloc_valid), .alloc_pd(alloc_pd), .alloc_epoch(alloc_epoch),
        .wb_valid(wb_valid), .wb_pd(wb_pd), .wb_data(wb_data), .wb_epoch(wb_epoch),
        .wakeup_valid(wakeup_valid), .wakeup_pd(wakeup_pd),
        .stale_drop_cnt(stale_drop_cnt), .ready_vec(ready_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        wk_t e;
        #1;
        for (int j = 0; j < 2; j++) begin
            if (wakeup_valid[j]) begin
                total++;
                if (wk_q.size() == 0) begin
                    bad++;
                    $display("FAIL wakeup_unexpected: port %0d pd %0d, want none", j, wakeup_pd[j]);
                end else begin
                    e = wk_q.pop_front();
                    if (e.port != j || int'(wakeup_pd[j]) != e.pd) begin
                        bad++;
                        $display("FAIL wakeup_pd: port %0d pd %0d, want port %0d pd %0d",
                                 j, wakeup_pd[j], e.port, e.pd);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        alloc_valid = '0; alloc_pd = '0; alloc_epoch = '0;
        wb_valid = '0; wb_pd = '0; wb_data = '0; wb_epoch = '0;
    endtask

    task automatic drive_wb(input int port, input wb_req_t r);
        wb_valid[port] = r.valid;
        wb_pd[port]    = r.pd;
        wb_data[port]  = r.data;
        wb_epoch[port] = r.epoch;
    endtask

    task automatic drive_alloc(input int port, input int pd, input int ep);
        alloc_valid[port] = 1'b1;
        alloc_pd[port]    = 6'(pd);
        alloc_epoch[port] = 4'(ep);
    endtask

    task automatic test_reset();
        raddr1 = {6'd5, 6'd5};
        raddr2 = {6'd5, 6'd5};
        #1;
        for (int p = 0; p < 2; p++) begin
            total++;
            if (rdata1[p] !== 32'h0 || rready1[p] !== 1'b1 || rdata2[p] !== 32'h0 || rready2[p] !== 1'b1) begin
                bad++;
                $display("FAIL reset_read%0d: d1 %h r1 %b d2 %h r2 %b, want 0/1", p,
                         rdata1[p], rready1[p], rdata2[p], rready2[p]);
            end
        end
        total++;
        if (ready_vec !== '1) begin bad++; $display("FAIL reset_ready_vec: %h, want all ones", ready_vec); end
        total++;
        if (stale_drop_cnt !== '0 || wakeup_valid !== 2'b00) begin
            bad++;
            $display("FAIL reset_cnt_wk: cnt %0d wk %b, want 0 00", stale_drop_cnt, wakeup_valid);
        end
    endtask

    task automatic test_alloc_wb_bypass();
        drive_alloc(0, 7, 1);
        tick();
        idle();
        total++;
        if (ready_vec[7] !== 1'b0) begin bad++; $display("FAIL alloc_ready7: %b, want 0", ready_vec[7]); end
        drive_wb(0, '{valid: 1'b1, pd: 6'd7, data: 32'hDEADBEEF, epoch: 4'd1});
        wk_q.push_back('{port: 0, pd: 7});
        raddr1[0] = 6'd7;
        #1;
        total++;
        if (rdata1[0] !== 32'hDEADBEEF || rready1[0] !== 1'b1) begin
            bad++;
            $display("FAIL bypass7: %h/%b, want deadbeef/1", rdata1[0], rready1[0]);
        end
        tick();
        idle();
        #1;
        total++;
        if (rdata1[0] !== 32'hDEADBEEF || rready1[0] !== 1'b1 || wk_q.size() != 0) begin
            bad++;
            $display("FAIL stored7: %h/%b pending %0d, want deadbeef/1 pending 0",
                     rdata1[0], rready1[0], wk_q.size());
        end
    endtask

    task automatic test_stale();
        drive_alloc(0, 9, 2);
        tick();
        idle();
        drive_wb(0, '{valid: 1'b1, pd: 6'd9, data: 32'h1234, epoch: 4'd1});
        raddr1[0] = 6'd9;
        #1;
        total++;
        if (rdata1[0] !== 32'h0 || rready1[0] !== 1'b0) begin
            bad++;
            $display("FAIL stale_bypass9: %h/%b, want 0/0", rdata1[0], rready1[0]);
        end
        tick();
        idle();
        #1;
        total++;
        if (rdata1[0] !== 32'h0 || rready1[0] !== 1'b0 || stale_drop_cnt !== 4'd1) begin
            bad++;
            $display("FAIL stale9: %h/%b cnt %0d, want 0/0 cnt 1", rdata1[0], rready1[0], stale_drop_cnt);
        end
    endtask

    task automatic test_alloc_wb_collision();
        drive_alloc(0, 12, 3);
        drive_wb(0, '{valid: 1'b1, pd: 6'd12, data: 32'h55, epoch: 4'd0});
        wk_q.push_back('{port: 0, pd: 12});
        raddr1[0] = 6'd12;
        #1;
        total++;
        if (rdata1[0] !== 32'h0 || rready1[0] !== 1'b1) begin
            bad++;
            $display("FAIL collide_bypass12: %h/%b, want 0/1", rdata1[0], rready1[0]);
        end
        tick();
        idle();
        #1;
        total++;
        if (rdata1[0] !== 32'h55 || rready1[0] !== 1'b0 || ready_vec[12] !== 1'b0) begin
            bad++;
            $display("FAIL collide12: %h/%b vec %b, want 55/0 vec 0", rdata1[0], rready1[0], ready_vec[12]);
        end
        drive_wb(1, '{valid: 1'b1, pd: 6'd12, data: 32'h66, epoch: 4'd3});
        wk_q.push_back('{port: 1, pd: 12});
        tick();
        idle();
        #1;
        total++;
        if (rdata1[0] !== 32'h66 || rready1[0] !== 1'b1 || stale_drop_cnt !== 4'd1 || wk_q.size() != 0) begin
            bad++;
            $display("FAIL epoch12: %h/%b cnt %0d pending %0d, want 66/1 cnt 1 pending 0",
                     rdata1[0], rready1[0], stale_drop_cnt, wk_q.size());
        end
    endtask

    task automatic test_multi_wb();
        drive_wb(0, '{valid: 1'b1, pd: 6'd20, data: 32'hAA, epoch: 4'd0});
        drive_wb(1, '{valid: 1'b1, pd: 6'd20, data: 32'hBB, epoch: 4'd0});
        wk_q.push_back('{port: 0, pd: 20});
        wk_q.push_back('{port: 1, pd: 20});
        raddr2[1] = 6'd20;
        #1;
        total++;
        if (rdata2[1] !== 32'hBB || rready2[1] !== 1'b1) begin
            bad++;
            $display("FAIL multi_bypass20: %h/%b, want bb/1", rdata2[1], rready2[1]);
        end
        tick();
        idle();
        #1;
        total++;
        if (rdata2[1] !== 32'hBB || wk_q.size() != 0) begin
            bad++;
            $display("FAIL multi20: %h pending %0d, want bb pending 0", rdata2[1], wk_q.size());
        end
    endtask

    task automatic test_zero_reg();
        drive_alloc(1, 0, 5);
        drive_wb(0, '{valid: 1'b1, pd: 6'd0, data: 32'h11, epoch: 4'd7});
        drive_wb(1, '{valid: 1'b1, pd: 6'd0, data: 32'hFF, epoch: 4'd0});
        raddr1[1] = 6'd0;
        raddr2[0] = 6'd0;
        #1;
        total++;
        if (rdata1[1] !== 32'h0 || rready1[1] !== 1'b1 || rdata2[0] !== 32'h0 || rready2[0] !== 1'b1) begin
            bad++;
            $display("FAIL zero_bypass: %h/%b %h/%b, want 0/1", rdata1[1], rready1[1], rdata2[0], rready2[0]);
        end
        tick();
        idle();
        #1;
        total++;
        if (rdata1[1] !== 32'h0 || rready1[1] !== 1'b1 || ready_vec[0] !== 1'b1 || stale_drop_cnt !== 4'd1) begin
            bad++;
            $display("FAIL zero_state: %h/%b vec %b cnt %0d, want 0/1 vec 1 cnt 1",
                     rdata1[1], rready1[1], ready_vec[0], stale_drop_cnt);
        end
    endtask

    task automatic test_saturate();
        int exp_cnt = 1;
        for (int c = 0; c < 9; c++) begin
            drive_wb(0, '{valid: 1'b1, pd: 6'd9, data: 32'h1, epoch: 4'd1});
            if (c != 8) drive_wb(1, '{valid: 1'b1, pd: 6'd9, data: 32'h2, epoch: 4'd0});
            exp_cnt = exp_cnt + ((c != 8) ? 2 : 1);
            if (exp_cnt > 15) exp_cnt = 15;
            tick();
            idle();
            total++;
            if (int'(stale_drop_cnt) != exp_cnt) begin
                bad++;
                $display("FAIL sat_cnt%0d: %0d, want %0d", c, stale_drop_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive_wb(0, '{valid: 1'b1, pd: 6'd20, data: 32'h77, epoch: 4'd0});
        wk_q.push_back('{port: 0, pd: 20});
        tick();
        idle();
        drive_alloc(0, 30, 1);
        drive_wb(1, '{valid: 1'b1, pd: 6'd21, data: 32'h88, epoch: 4'd0});
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (wakeup_valid !== 2'b00 || stale_drop_cnt !== 4'd0 || ready_vec !== '1) begin
            bad++;
            $display("FAIL rst_async: wk %b cnt %0d vec %h, want 00 0 all ones",
                     wakeup_valid, stale_drop_cnt, ready_vec);
        end
        idle();
        raddr1[0] = 6'd20;
        raddr1[1] = 6'd12;
        #1;
        total++;
        if (rdata1[0] !== 32'h0 || rdata1[1] !== 32'h0 || rready1[1] !== 1'b1) begin
            bad++;
            $display("FAIL rst_mem: %h %h/%b, want 0 0/1", rdata1[0], rdata1[1], rready1[1]);
        end
        tick();
        tick();
        rst_n = 1'b1;
        raddr2[0] = 6'd21;
        raddr2[1] = 6'd30;
        tick();
        total++;
        if (rdata2[0] !== 32'h0 || rready2[0] !== 1'b1 || rready2[1] !== 1'b1 || wk_q.size() != 0) begin
            bad++;
            $display("FAIL rst_after: %h/%b r30 %b pending %0d, want 0/1 r30 1 pending 0",
                     rdata2[0], rready2[0], rready2[1], wk_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        raddr1 = '0;
        raddr2 = '0;
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        test_reset();
        tick();
        test_alloc_wb_bypass();
        test_stale();
        test_alloc_wb_collision();
        test_multi_wb();
        test_zero_reg();
        test_saturate();
        test_reset_mid();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prf_mp.md
Name: prf_mp

Overview:
Multi-ported, epoch-filtered physical register file. It is the generalised successor of the single-writeback PRF and serves the issue stage's operand reads. It adds:
- parametrised read, writeback and allocate port counts
- optional same-cycle writeback-to-read bypass
- optional hardwired zero register
- a registered wakeup broadcast
- a saturating counter of stale (epoch-mismatched) writebacks dropped

Parameters:
- PHYS_REGS, 64, number of physical registers (power of 2, >= 2).
- DW, 32, data width.
- PHYS_W, $clog2(PHYS_REGS), physical register index width.
- NUM_RD, FU_NUM, number of read-port pairs (rs1/rs2 per pair).
- NUM_WB, 2, number of writeback ports.
- NUM_ALLOC, 2, number of allocate/recovery ports.
- BYPASS, 1, 1 = accepted same-cycle writebacks forward to read ports.
- ZERO_REG, 1, 1 = physical register 0 reads 0 and is always ready.
- CNT_W, 16, stale-drop counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- raddr1  in  NUM_RD x PHYS_W  rs1 read addresses.
- rdata1  out  NUM_RD x DW  rs1 read data.
- rready1  out  NUM_RD x 1  rs1 ready.
- raddr2  in  NUM_RD x PHYS_W  rs2 read addresses.
- rdata2  out  NUM_RD x DW  rs2 read data.
- rready2  out  NUM_RD x 1  rs2 ready.
- alloc_valid  in  NUM_ALLOC x 1  allocate request: mark destination not-ready.
- alloc_pd  in  NUM_ALLOC x PHYS_W  register to allocate.
- alloc_epoch  in  NUM_ALLOC x EPOCH_W  epoch to tag on the allocated register.
- wb_valid  in  NUM_WB x 1  writeback request.
- wb_pd  in  NUM_WB x PHYS_W  writeback destination.
- wb_data  in  NUM_WB x DW  writeback data.
- wb_epoch  in  NUM_WB x EPOCH_W  producer's epoch.
- wakeup_valid  out  NUM_WB x 1  registered: writeback accepted last cycle.
- wakeup_pd  out  NUM_WB x PHYS_W  registered: register woken.
- stale_drop_cnt  out  CNT_W  saturating count of dropped writebacks.
- ready_vec  out  PHYS_REGS  all ready bits, registered state.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - mem = 0, ready = 1, epoch = 0 for every register.
  - wakeup_valid = 0, wakeup_pd = 0, stale_drop_cnt = 0.
  - ready_vec = all ones; read outputs reflect the reset state.
  - Reset mid-operation discards all in-flight allocate/writeback effects.
- Reads are combinational from registered state, zero latency.
  - With BYPASS=1, an accepted writeback this cycle to the same pd overrides the stored value: data = wb_data, ready = 1. Highest-index matching WB port wins.
  - Bypass is suppressed if a same-cycle allocate targets that pd; ready stays as stored.
- Accept rule: WB port j is accepted iff wb_valid[j] and epoch[wb_pd[j]] == wb_epoch[j], compared against the pre-edge epoch.
  - Accepted: mem <= wb_data and ready <= 1 at the edge.
  - Not accepted (stale): dropped, state unchanged, stale_drop_cnt += 1 per stale port. Multiple stale ports in one cycle add their count. The counter saturates at all ones.
- Allocate: ready[alloc_pd] <= 0 and epoch[alloc_pd] <= alloc_epoch at the edge.
- Same pd, same cycle, allocate vs accepted writeback:
  - mem takes wb_data.
  - ready = 0 and epoch = alloc_epoch; allocate wins the ready bit and epoch.
- Same pd on multiple WB ports: highest index wins mem. Same pd on multiple allocate ports: highest index wins epoch. Both are legal and deterministic; upstream should not produce them.
- ZERO_REG=1:
  - Register 0 reads data 0 and ready 1 on every port, and ready_vec[0] = 1.
  - Writebacks and allocates to register 0 are ignored.
  - A writeback to register 0 is neither counted stale nor woken.
- Wakeup: wakeup_valid[j] <= accepted[j] and wakeup_pd[j] <= wb_pd[j], one cycle after acceptance.
  - Wakeup fires even if a same-cycle allocate cleared ready; consumers re-check rready.

Decomposition:
- EPOCH_W and FU_NUM stay in the shared defines header.
- Add to the shared package:
  - typedef phys_idx_t (PHYS_W bits).
  - typedef epoch_t.
  - struct wb_req_t {valid, pd, data, epoch}.
- One natural sub-module, prf_wb_arb: per-register priority resolution of WB/allocate write enables and selected data/epoch. It is instantiated once and purely combinational.
- The top level holds the state, the bypass muxes, wakeup registers and the counter.

Test Plan:
- Reset then read pd 5 on all ports -> data 0, ready 1. ready_vec = all ones. stale_drop_cnt 0.
- Allocate pd 7 with epoch 1. Next cycle WB port 0: pd 7, data 0xDEADBEEF, epoch 1.
  - Same-cycle read of pd 7 (BYPASS=1) -> 0xDEADBEEF, ready 1.
  - Following cycle: wakeup_valid[0] = 1, wakeup_pd[0] = 7.
- Allocate pd 9 with epoch 2. WB pd 9, data 0x1234, epoch 1 -> dropped; mem[9] stays 0, ready stays 0, stale_drop_cnt = 1, no wakeup.
- Same cycle: allocate pd 12 (epoch 3) and accepted WB pd 12 with the old epoch, data 0x55 -> mem[12] = 0x55, ready[12] = 0, epoch[12] = 3.
- WB port 0 and port 1 both to pd 20, data 0xAA and 0xBB, matching epoch -> mem[20] = 0xBB. Bypass read returns 0xBB.
- ZERO_REG=1: WB pd 0, data 0xFF -> reads of pd 0 return 0, ready 1, no wakeup. Separately, force the counter to all ones, then a stale WB -> counter holds at all ones. Assert rst_n low mid-burst -> all state returns to reset values immediately.
